// File: rtl/mips_dmem_io_ctrl_pkg.sv
// mips_dmem_io_ctrl_pkg: I/O page offsets, default address map and timer control layout
package mips_dmem_io_ctrl_pkg;
    localparam logic [31:0] IO_BASE_DEF  = 32'hFFFF_0000;
    localparam logic [31:0] RAM_BASE_DEF = 32'h1000_0000;
    localparam logic [11:0] OFF_LED    = 12'h000;
    localparam logic [11:0] OFF_SW     = 12'h004;
    localparam logic [11:0] OFF_TCTRL  = 12'h010;
    localparam logic [11:0] OFF_TLOAD  = 12'h014;
    localparam logic [11:0] OFF_TCOUNT = 12'h018;
    localparam logic [11:0] OFF_TSTAT  = 12'h01C;
    localparam logic [11:0] OFF_TXDATA = 12'h020;
    localparam logic [11:0] OFF_TXSTAT = 12'h024;
    typedef struct packed {
        logic autoreload;
        logic en;
    } tctrl_t;
endpackage

// File: rtl/flopr.sv
// flopr: resettable register, used here as one stage of the switch synchronizer
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) q <= reset ? '0 : d;
endmodule

// File: rtl/mips_dmem_io_ctrl_tx_fifo.sv
// io_tx_fifo: byte TX FIFO with registered head, sticky overflow and occupancy level
module io_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     ovf_clr_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic overflow_q, pop, accept;
    assign level_o    = wptr_q - rptr_q;
    assign empty_o    = level_o == '0;
    assign full_o     = level_o[AW];
    assign valid_o    = !empty_o;
    assign dout_o     = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    assign overflow_o = overflow_q;
    assign pop        = valid_o & ready_i;
    // a pop frees the head slot in the same edge, so a full FIFO can still take a push
    assign accept     = push_i & (!full_o | pop);
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            overflow_q <= (push_i & !accept) | (overflow_q & !ovf_clr_i);
        end
    end
    always_ff @(posedge clk) if (accept) mem_q[wptr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/mips_dmem_io_ctrl.sv
// mips_dmem_io_ctrl: MEM-stage data bus decode to RAM or the I/O page (LEDs, switches, timer, TX FIFO)
module mips_dmem_io_ctrl
    import mips_dmem_io_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = IO_BASE_DEF,
    parameter logic [31:0] RAM_BASE = RAM_BASE_DEF,
    parameter int          RAM_AW   = 13,
    parameter int          TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int LW = $clog2(TX_DEPTH) + 1;
    logic ram_sel, io_sel, io_wr, expire, tx_full, tx_empty, tx_ovf;
    logic expired_q, expired_d;
    logic [11:0] off;
    logic [15:0] sw_meta, sw_sync, leds_q, leds_d;
    logic [31:0] tload_q, tload_d, tcount_q, tcount_d, io_rdata;
    logic [LW-1:0] tx_level;
    tctrl_t tctrl_q, tctrl_d;
    assign ram_sel     = memaddr[31:RAM_AW] == RAM_BASE[31:RAM_AW];
    assign io_sel      = memaddr[31:12] == IO_BASE[31:12];
    assign off         = memaddr[11:0];
    assign io_wr       = memwrite & io_sel;
    assign ram_we      = memwrite & ram_sel;
    assign leds        = leds_q;
    assign expire      = tctrl_q.en & (tcount_q == '0);
    assign memreaddata = ram_sel ? ram_rdata : io_sel ? io_rdata : '0;
    flopr #(.WIDTH(16)) u_sync1 (.clk(clk), .reset(reset), .d(switches), .q(sw_meta));
    flopr #(.WIDTH(16)) u_sync2 (.clk(clk), .reset(reset), .d(sw_meta), .q(sw_sync));
    io_tx_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push_i(io_wr & (off == OFF_TXDATA)), .din_i(memwritedata[7:0]),
        .ovf_clr_i(io_wr & (off == OFF_TXSTAT) & memwritedata[2]), .ready_i(tx_ready),
        .valid_o(tx_valid), .dout_o(tx_data), .full_o(tx_full), .empty_o(tx_empty),
        .level_o(tx_level), .overflow_o(tx_ovf)
    );
    always_comb begin
        leds_d    = (io_wr && off == OFF_LED) ? memwritedata[15:0] : leds_q;
        tload_d   = (io_wr && off == OFF_TLOAD) ? memwritedata : tload_q;
        tctrl_d   = (io_wr && off == OFF_TCTRL) ? tctrl_t'(memwritedata[1:0]) :
                    (expire && !tctrl_q.autoreload) ? tctrl_t'(2'b00) : tctrl_q;
        tcount_d  = (io_wr && off == OFF_TLOAD) ? memwritedata :
                    !tctrl_q.en ? tcount_q :
                    (tcount_q != '0) ? tcount_q - 32'd1 :
                    tctrl_q.autoreload ? tload_q : '0;
        // an expiry in the same cycle as a clear keeps the flag set
        expired_d = expire | (expired_q & !(io_wr && off == OFF_TSTAT && memwritedata[0]));
    end
    always_comb begin
        io_rdata = '0;
        case (off)
            OFF_LED:    io_rdata = {16'h0, leds_q};
            OFF_SW:     io_rdata = {16'h0, sw_sync};
            OFF_TCTRL:  io_rdata = {30'h0, tctrl_q};
            OFF_TLOAD:  io_rdata = tload_q;
            OFF_TCOUNT: io_rdata = tcount_q;
            OFF_TSTAT:  io_rdata = {31'h0, expired_q};
            OFF_TXSTAT: io_rdata = {24'h0, 4'(tx_level), 1'b0, tx_ovf, tx_empty, tx_full};
            default:    io_rdata = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q    <= '0;
            tload_q   <= '0;
            tcount_q  <= '0;
            tctrl_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            leds_q    <= leds_d;
            tload_q   <= tload_d;
            tcount_q  <= tcount_d;
            tctrl_q   <= tctrl_d;
            expired_q <= expired_d;
        end
    end
endmodule

// File: tb/tb_mips_dmem_io_ctrl.sv
// tb_mips_dmem_io_ctrl: directed stimulus with a cycle-level reference model and per-cycle compare
module tb_mips_dmem_io_ctrl;
    localparam logic [31:0] IO = 32'hFFFF_0000;
    logic        clk = 0, reset = 1, memwrite = 0, ram_we, tx_valid, tx_ready = 0;
    logic [31:0] memaddr = 0, memwritedata = 0, memreaddata, ram_rdata;
    logic [15:0] switches = 16'hBEEF, leds;
    logic [7:0]  tx_data;
    int n_tests = 0, n_fail = 0;
    bit live = 0;
    logic [15:0] m_leds, m_sw1, m_sw2;
    logic [31:0] m_tload, m_tcount;
    bit m_en, m_auto, m_expired, m_ovf;
    logic [7:0] m_q[$];

    assign ram_rdata = memaddr ^ 32'hA5A5_5A5A;
    always #5 clk = ~clk;

    mips_dmem_io_ctrl dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
        .memwritedata(memwritedata), .memreaddata(memreaddata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .switches(switches), .leds(leds), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready)
    );

    function automatic bit in_ram(logic [31:0] a);
        return a >= 32'h1000_0000 && a < 32'h1000_2000;
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        if (in_ram(a)) return a ^ 32'hA5A5_5A5A;
        if (a[31:12] != 20'hFFFF0) return 0;
        case (a[11:0])
            12'h000: return {16'h0, m_leds};
            12'h004: return {16'h0, m_sw2};
            12'h010: return {30'h0, m_auto, m_en};
            12'h014: return m_tload;
            12'h018: return m_tcount;
            12'h01C: return {31'h0, m_expired};
            12'h024: return {24'h0, 4'(m_q.size()), 1'b0, m_ovf, m_q.size() == 0, m_q.size() == 8};
            default: return 0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: advances once per rising edge from the inputs held during that cycle
    initial forever begin
        bit wr, ev, pop, rej;
        logic [11:0] o;
        logic [31:0] wd, ncount;
        @(posedge clk);
        if (reset) begin
            m_leds = 0; m_sw1 = 0; m_sw2 = 0; m_tload = 0; m_tcount = 0;
            m_en = 0; m_auto = 0; m_expired = 0; m_ovf = 0;
            m_q.delete();
            live = 1;
        end else begin
            wr = memwrite && memaddr[31:12] == 20'hFFFF0;
            o = memaddr[11:0];
            wd = memwritedata;
            ev = m_en && m_tcount == 0;
            pop = m_q.size() != 0 && tx_ready;
            rej = 0;
            m_sw2 = m_sw1;
            m_sw1 = switches;
            if (wr && o == 12'h000) m_leds = wd[15:0];
            if (wr && o == 12'h014) ncount = wd;
            else if (!m_en) ncount = m_tcount;
            else if (m_tcount != 0) ncount = m_tcount - 1;
            else ncount = m_auto ? m_tload : 0;
            if (wr && o == 12'h014) m_tload = wd;
            m_tcount = ncount;
            if (wr && o == 12'h010) begin
                m_auto = wd[1];
                m_en = wd[0];
            end else if (ev && !m_auto) m_en = 0;
            m_expired = ev || (m_expired && !(wr && o == 12'h01C && wd[0]));
            if (pop) void'(m_q.pop_front());
            if (wr && o == 12'h020) begin
                if (m_q.size() < 8) m_q.push_back(wd[7:0]);
                else rej = 1;
            end
            m_ovf = rej || (m_ovf && !(wr && o == 12'h024 && wd[2]));
        end
    end

    initial forever begin
        @(negedge clk);
        if (live) begin
            chk("rdata", memreaddata, m_read(memaddr));
            chk("ram_we", {31'h0, ram_we}, {31'h0, memwrite && in_ram(memaddr)});
            chk("leds", {16'h0, leds}, {16'h0, m_leds});
            chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
            chk("tx_data", {24'h0, tx_data}, {24'h0, m_q.size() != 0 ? m_q[0] : 8'h00});
        end
    end

    task automatic op(logic [31:0] a, logic [31:0] d);
        memwrite = 1; memaddr = a; memwritedata = d;
        @(posedge clk); #1;
        memwrite = 0; memaddr = 0;
    endtask

    task automatic ld(string name, logic [31:0] a, logic [31:0] exp);
        memaddr = a;
        #2 chk(name, memreaddata, exp);
        @(posedge clk); #1;
        memaddr = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        reset = 0;
        chk("rst_leds", {16'h0, leds}, 0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 0);
        chk("rst_tx_data", {24'h0, tx_data}, 0);
        // LED store/load, RAM store, switches
        op(IO, 32'h1234);
        chk("t1_leds", {16'h0, leds}, 32'h1234);
        ld("t1_led_rd", IO, 32'h1234);
        memwrite = 1; memaddr = 32'h1000_0040; memwritedata = 32'hDEAD_0000;
        #2 chk("t1_ram_we", {31'h0, ram_we}, 1);
        @(posedge clk); #1;
        memwrite = 0; memaddr = 0;
        chk("t1_leds_kept", {16'h0, leds}, 32'h1234);
        ld("t1_ram_rd", 32'h1000_0040, 32'hB5A5_5A1A);
        ld("t1_sw", IO + 32'h4, 32'hBEEF);
        // autoreload timer
        op(IO + 32'h14, 3);
        op(IO + 32'h10, 3);
        ld("t2_cnt3", IO + 32'h18, 3);
        ld("t2_cnt2", IO + 32'h18, 2);
        ld("t2_cnt1", IO + 32'h18, 1);
        ld("t2_cnt0", IO + 32'h18, 0);
        ld("t2_reload", IO + 32'h18, 3);
        op(IO + 32'h1C, 1);
        ld("t2_cleared", IO + 32'h1C, 0);
        op(IO + 32'h1C, 1);
        ld("t2_set_wins", IO + 32'h1C, 1);
        op(IO + 32'h10, 0);
        op(IO + 32'h1C, 1);
        // one-shot timer
        op(IO + 32'h14, 2);
        op(IO + 32'h10, 1);
        ld("t3_cnt2", IO + 32'h18, 2);
        ld("t3_cnt1", IO + 32'h18, 1);
        ld("t3_cnt0", IO + 32'h18, 0);
        ld("t3_en_off", IO + 32'h10, 0);
        ld("t3_hold0", IO + 32'h18, 0);
        ld("t3_expired", IO + 32'h1C, 1);
        // FIFO fill past full, then drain
        tx_ready = 0;
        for (int i = 0; i < 9; i++) op(IO + 32'h20, 32'h41 + i);
        chk("t4_head", {24'h0, tx_data}, 32'h41);
        ld("t4_stat_full", IO + 32'h24, 32'h85);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #2 chk("t4_drain", {23'h0, tx_valid, tx_data}, 32'h100 | (32'h41 + i));
            @(posedge clk); #1;
        end
        ld("t4_stat_empty", IO + 32'h24, 32'h06);
        op(IO + 32'h24, 4);
        ld("t4_ovf_clr", IO + 32'h24, 32'h02);
        // push while full and popping
        tx_ready = 0;
        for (int i = 0; i < 8; i++) op(IO + 32'h20, 32'h60 + i);
        ld("t5_stat_full", IO + 32'h24, 32'h81);
        tx_ready = 1;
        op(IO + 32'h20, 32'h5A);
        ld("t5_stat_after", IO + 32'h24, 32'h81);
        repeat (10) begin @(posedge clk); #1; end
        ld("t5_drained", IO + 32'h24, 32'h02);
        // reset mid-stream
        tx_ready = 0;
        op(IO, 32'h00FF);
        for (int i = 0; i < 3; i++) op(IO + 32'h20, 32'h70 + i);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("t6_tx_valid", {31'h0, tx_valid}, 0);
        chk("t6_leds", {16'h0, leds}, 0);
        ld("t6_stat", IO + 32'h24, 32'h02);
        ld("t6_unmapped", 32'h2000_0000, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
